pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core.
- Successor to the fixed-field stage registers. Carries one data bundle and one control bundle per beat.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered and back-pressure does not ripple combinationally through the pipe.
- Supports a synchronous flush that inserts a programmable bubble (NOP) control pattern.

Parameters:
- DATA_W, 96, width of the datapath bundle (operands, immediate, PC, ...).
- CTRL_W, 16, width of the control bundle (ALU op, write-enables, select bits, ...).
- BUBBLE_CTRL, 16'h0001, control value presented when no valid beat is held (reset, flush, drain); bit pattern of a NOP.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
- flush  in  1  synchronous discard of every held beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; driven from register state only.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  main register holds a valid beat.
- out_ready  in  1  downstream accepts; 0 = stall.
- out_data  out  DATA_W  held datapath bundle.
- out_ctrl  out  CTRL_W  held control bundle; BUBBLE_CTRL when out_valid=0.
- occupancy  out  2  beats held: 0, 1 or 2.

Behaviour:
- State: main register (m_valid, m_data, m_ctrl) and skid register (s_valid, s_data, s_ctrl).
  - out_* = main register.
  - in_ready = ~s_valid.
  - occupancy = m_valid + s_valid.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset=0, async):
  - m_valid=0, s_valid=0.
  - m_data=0, m_ctrl=BUBBLE_CTRL; skid data/ctrl=0.
  - Hence out_valid=0, in_ready=1, occupancy=0.
- Priority per rising edge: flush > normal update.
- flush=1:
  - m_valid=0, s_valid=0, m_data=0, m_ctrl=BUBBLE_CTRL.
  - A beat offered in the same cycle is discarded even if in_ready=1.
  - out_ready is ignored that cycle.
- Normal update, by case:
  - m empty, in_fire: main <= in; latency 1 cycle in_fire -> out_valid.
  - m full, out_fire, s empty, in_fire: main <= in (full throughput, 1 beat/cycle).
  - m full, out_fire, s empty, no in_fire: m_valid=0, m_data=0, m_ctrl=BUBBLE_CTRL.
  - m full, !out_fire, in_fire: skid <= in, s_valid=1; in_ready=0 from next cycle.
  - s full, out_fire: main <= skid, s_valid=0; no in_fire is possible because in_ready=0. in_ready=1 next cycle.
  - s full, !out_fire: hold everything.
  - Otherwise hold.
- Invariants:
  - s_valid=1 implies m_valid=1.
  - Beats leave in arrival order; none are lost or duplicated except on flush.
  - out_data/out_ctrl stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all held beats are dropped immediately, including while the skid is full.
- Deassertion of reset is synchronised externally; the block assumes a clean release relative to clk.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> out_valid=0, out_ctrl=16'h0001, out_data=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, send in_data=1..8 with in_ctrl=16'h00A0+i on consecutive cycles -> out_data=1..8 in order, each one cycle after acceptance, in_ready never drops.
- Back-pressure: push 0x11, then 0x22 with out_ready=0 -> occupancy=2, in_ready=0 on the following cycle, 0x33 not accepted. Raise out_ready -> outputs 0x11, 0x22, then 0x33 once re-offered, with no loss.
- Flush with skid full: hold 0x44/0x55, assert flush for 1 cycle while offering 0x66 -> next cycle out_valid=0, out_ctrl=16'h0001, occupancy=0, in_ready=1; 0x66 never appears.
- Drain to bubble: single beat 0x77, out_ready=1, no further input -> 0x77 valid for one cycle, then out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL.
- Async reset mid-stall: skid full, drop reset between clock edges -> outputs return to reset values before the next edge; random valid/ready traffic afterwards is in order per scoreboard.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a 2-entry skid buffer and synchronous flush.
// Upstream ready comes straight from the skid valid flop, so stalls never ripple combinationally.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;

  logic              m_valid_nx, s_valid_nx;
  logic [DATA_W-1:0] m_data_nx, s_data_nx;
  logic [CTRL_W-1:0] m_ctrl_nx, s_ctrl_nx;

  logic in_fire, out_fire;

  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;

  always_comb begin
    m_valid_nx = m_valid;
    m_data_nx  = m_data;
    m_ctrl_nx  = m_ctrl;
    s_valid_nx = s_valid;
    s_data_nx  = s_data;
    s_ctrl_nx  = s_ctrl;

    if (flush) begin
      m_valid_nx = 1'b0;
      m_data_nx  = '0;
      m_ctrl_nx  = BUBBLE_CTRL;
      s_valid_nx = 1'b0;
      s_data_nx  = '0;
      s_ctrl_nx  = '0;
    end else if (s_valid) begin
      // Skid full implies in_ready=0, so only the skid can advance into main.
      if (out_fire) begin
        m_data_nx  = s_data;
        m_ctrl_nx  = s_ctrl;
        s_valid_nx = 1'b0;
        s_data_nx  = '0;
        s_ctrl_nx  = '0;
      end
    end else if (m_valid) begin
      if (out_fire) begin
        if (in_fire) begin
          m_data_nx = in_data;
          m_ctrl_nx = in_ctrl;
        end else begin
          m_valid_nx = 1'b0;
          m_data_nx  = '0;
          m_ctrl_nx  = BUBBLE_CTRL;
        end
      end else if (in_fire) begin
        s_valid_nx = 1'b1;
        s_data_nx  = in_data;
        s_ctrl_nx  = in_ctrl;
      end
    end else if (in_fire) begin
      m_valid_nx = 1'b1;
      m_data_nx  = in_data;
      m_ctrl_nx  = in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= BUBBLE_CTRL;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else begin
      m_valid <= m_valid_nx;
      m_data  <= m_data_nx;
      m_ctrl  <= m_ctrl_nx;
      s_valid <= s_valid_nx;
      s_data  <= s_data_nx;
      s_ctrl  <= s_ctrl_nx;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector table plus async-reset and random scoreboard sequences for pipe_stage_buf.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.DATA_W(96), .CTRL_W(16), .BUBBLE_CTRL(16'h0001)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [95:0] d;
    logic [15:0] c;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [95:0] ed;
    logic [15:0] ec;
    logic        eir;
    logic [1:0]  eo;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic iv, logic [95:0] d, logic [15:0] c, logic ordy,
                              logic fl, logic ev, logic [95:0] ed, logic [15:0] ec, logic eir,
                              logic [1:0] eo);
    vec_t v;
    v.name = name; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eir = eir; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string name, logic ev, logic [95:0] ed, logic [15:0] ec, logic eir,
                         logic [1:0] eo);
    chk({name, ".out_valid"}, 128'(out_valid), 128'(ev));
    chk({name, ".out_data"},  128'(out_data),  128'(ed));
    chk({name, ".out_ctrl"},  128'(out_ctrl),  128'(ec));
    chk({name, ".in_ready"},  128'(in_ready),  128'(eir));
    chk({name, ".occupancy"}, 128'(occupancy), 128'(eo));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0;
  endtask

  logic [95:0] q_data[$];
  logic [15:0] q_ctrl[$];

  initial begin
    logic [95:0] seq;
    logic        ifire, ofire;

    reset = 1'b0; out_ready = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_all("reset_idle", 1'b0, 96'h0, 16'h0001, 1'b1, 2'd0);
    @(posedge clk); #1;
    chk_all("idle_after_reset", 1'b0, 96'h0, 16'h0001, 1'b1, 2'd0);

    // Streaming: each beat shows one cycle after acceptance.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk("stream", 1, 96'(i), 16'(16'h00A0 + i), 1, 0,
                        1, 96'(i), 16'(16'h00A0 + i), 1, 2'd1));
    vecs.push_back(mk("stream_drain", 0, 0, 0, 1, 0, 0, 0, 16'h0001, 1, 2'd0));
    // Back-pressure into the skid.
    vecs.push_back(mk("bp_push11", 1, 96'h11, 16'h0011, 0, 0, 1, 96'h11, 16'h0011, 1, 2'd1));
    vecs.push_back(mk("bp_push22", 1, 96'h22, 16'h0022, 0, 0, 1, 96'h11, 16'h0011, 0, 2'd2));
    vecs.push_back(mk("bp_reject33", 1, 96'h33, 16'h0033, 0, 0, 1, 96'h11, 16'h0011, 0, 2'd2));
    vecs.push_back(mk("bp_release", 1, 96'h33, 16'h0033, 1, 0, 1, 96'h22, 16'h0022, 1, 2'd1));
    vecs.push_back(mk("bp_take33", 1, 96'h33, 16'h0033, 1, 0, 1, 96'h33, 16'h0033, 1, 2'd1));
    vecs.push_back(mk("bp_drain", 0, 0, 0, 1, 0, 0, 0, 16'h0001, 1, 2'd0));
    // Flush with skid full while a beat is offered.
    vecs.push_back(mk("fl_push44", 1, 96'h44, 16'h0044, 0, 0, 1, 96'h44, 16'h0044, 1, 2'd1));
    vecs.push_back(mk("fl_push55", 1, 96'h55, 16'h0055, 0, 0, 1, 96'h44, 16'h0044, 0, 2'd2));
    vecs.push_back(mk("fl_flush", 1, 96'h66, 16'h0066, 1, 1, 0, 0, 16'h0001, 1, 2'd0));
    vecs.push_back(mk("fl_after", 0, 0, 0, 1, 0, 0, 0, 16'h0001, 1, 2'd0));
    vecs.push_back(mk("fl_empty_offer", 1, 96'h99, 16'h0099, 1, 1, 0, 0, 16'h0001, 1, 2'd0));
    // Drain to bubble.
    vecs.push_back(mk("dr_77", 1, 96'h77, 16'h0077, 1, 0, 1, 96'h77, 16'h0077, 1, 2'd1));
    vecs.push_back(mk("dr_bubble", 0, 0, 0, 1, 0, 0, 0, 16'h0001, 1, 2'd0));

    foreach (vecs[k]) begin
      in_valid = vecs[k].iv; in_data = vecs[k].d; in_ctrl = vecs[k].c;
      out_ready = vecs[k].ordy; flush = vecs[k].fl;
      @(posedge clk); #1;
      chk_all(vecs[k].name, vecs[k].ev, vecs[k].ed, vecs[k].ec, vecs[k].eir, vecs[k].eo);
    end

    // Async reset while the skid is full: outputs clear before the next edge.
    idle_inputs(); out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'hA1; in_ctrl = 16'h00A1;
    @(posedge clk); #1;
    in_data = 96'hA2; in_ctrl = 16'h00A2;
    @(posedge clk); #1;
    idle_inputs();
    chk_all("ar_full", 1'b1, 96'hA1, 16'h00A1, 1'b0, 2'd2);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_all("ar_async", 1'b0, 96'h0, 16'h0001, 1'b1, 2'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk_all("ar_release", 1'b0, 96'h0, 16'h0001, 1'b1, 2'd0);

    // Random traffic against an ordered scoreboard.
    seq = 96'h0;
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = {32'hC0DE_0000, seq[63:0]};
      in_ctrl   = seq[15:0] ^ 16'h5A5A;
      ifire = in_valid & in_ready;
      ofire = out_valid & out_ready;
      if (ofire) begin
        if (q_data.size() == 0) begin
          chk("rnd_unexpected_out", 128'(out_data), 128'hDEAD);
        end else begin
          chk("rnd_data", 128'(out_data), 128'(q_data.pop_front()));
          chk("rnd_ctrl", 128'(out_ctrl), 128'(q_ctrl.pop_front()));
        end
      end
      if (ifire) begin
        q_data.push_back(in_data);
        q_ctrl.push_back(in_ctrl);
        seq = seq + 96'd1;
      end
      @(posedge clk); #1;
      chk("rnd_occupancy", 128'(occupancy), 128'(q_data.size()));
    end

    idle_inputs(); out_ready = 1'b1;
    for (int n = 0; n < 10 && q_data.size() != 0; n++) begin
      if (out_valid) begin
        chk("drain_data", 128'(out_data), 128'(q_data.pop_front()));
        chk("drain_ctrl", 128'(out_ctrl), 128'(q_ctrl.pop_front()));
      end
      @(posedge clk); #1;
    end
    chk("drain_left", 128'(q_data.size()), 128'd0);
    chk_all("drain_end", 1'b0, 96'h0, 16'h0001, 1'b1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
